// File: rtl/graphic_pkg.sv
// rtl/graphic_pkg.sv - screen geometry, coordinate widths and game state encoding
package graphic_pkg;
  localparam int SCREEN_WIDTH  = 800;
  localparam int SCREEN_HEIGHT = 600;
  localparam int BALL_RADIUS   = 20;
  localparam int X_W           = $clog2(SCREEN_WIDTH);
  localparam int Y_W           = $clog2(SCREEN_HEIGHT);
  // Horizontal counter also spans the blanking interval, hence one bit wider.
  localparam int H_W           = 11;
  localparam int CALC_W        = 12;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_PLAY = 2'd1,
    ST_FAIL = 2'd2
  } game_state_t;

  function automatic logic signed [CALC_W-1:0] clamp_coord(
    input logic signed [CALC_W-1:0] val,
    input logic signed [CALC_W-1:0] lo,
    input logic signed [CALC_W-1:0] hi
  );
    if (val < lo) return lo;
    if (val > hi) return hi;
    return val;
  endfunction
endpackage

// File: rtl/frame_tick_gen.sv
// rtl/frame_tick_gen.sv - one-cycle pulse when scan-out first reaches the line below the visible area
module frame_tick_gen
  import graphic_pkg::*;
(
  input  logic           i_clk,
  input  logic           i_rst_n,
  input  logic [H_W-1:0] i_h_coord,
  input  logic [Y_W-1:0] i_v_coord,
  output logic           o_frame_tick
);
  logic cond;
  logic cond_q;

  assign cond = (i_v_coord == Y_W'(SCREEN_HEIGHT)) && (i_h_coord == '0);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      cond_q       <= 1'b0;
      o_frame_tick <= 1'b0;
    end else begin
      cond_q       <= cond;
      o_frame_tick <= cond & ~cond_q;
    end
  end
endmodule

// File: rtl/ball_motion_ctrl.sv
// rtl/ball_motion_ctrl.sv - per-frame ball movement, clamping, centre safety sampling and game FSM
module ball_motion_ctrl
  import graphic_pkg::*;
#(
  parameter int STEP    = 4,
  parameter int START_X = 400,
  parameter int START_Y = 300
) (
  input  logic           i_clk,
  input  logic           i_rst_n,
  input  logic           i_btn_up,
  input  logic           i_btn_down,
  input  logic           i_btn_left,
  input  logic           i_btn_right,
  input  logic           i_start,
  input  logic           i_disp_enbl,
  input  logic [H_W-1:0] i_h_coord,
  input  logic [Y_W-1:0] i_v_coord,
  input  logic           i_is_safe,
  output logic [X_W-1:0] o_ball_x,
  output logic [Y_W-1:0] o_ball_y,
  output logic [1:0]     o_state,
  output logic           o_frame_tick
);
  localparam logic [X_W-1:0] START_XV = X_W'(START_X);
  localparam logic [Y_W-1:0] START_YV = Y_W'(START_Y);
  localparam logic signed [CALC_W-1:0] STEP_S = CALC_W'(STEP);
  localparam logic signed [CALC_W-1:0] MIN_S  = CALC_W'(BALL_RADIUS);
  localparam logic signed [CALC_W-1:0] MAX_X  = CALC_W'(SCREEN_WIDTH - 1 - BALL_RADIUS);
  localparam logic signed [CALC_W-1:0] MAX_Y  = CALC_W'(SCREEN_HEIGHT - 1 - BALL_RADIUS);

  logic [1:0] state_q;
  logic       centre_seen;
  logic       centre_safe;
  logic       start_prev;
  logic       start_rise;
  logic       centre_hit;

  logic signed [CALC_W-1:0] dx, dy;
  logic signed [CALC_W-1:0] nx, ny;
  logic [X_W-1:0]           next_x;
  logic [Y_W-1:0]           next_y;

  frame_tick_gen u_frame_tick_gen (
    .i_clk       (i_clk),
    .i_rst_n     (i_rst_n),
    .i_h_coord   (i_h_coord),
    .i_v_coord   (i_v_coord),
    .o_frame_tick(o_frame_tick)
  );

  assign start_rise = i_start & ~start_prev;
  assign centre_hit = i_disp_enbl && (i_h_coord == H_W'(o_ball_x)) && (i_v_coord == o_ball_y);

  // Opposite buttons cancel; the sum is formed wide and signed so the clamp sees true underflow.
  always_comb begin
    dx = '0;
    dy = '0;
    if (i_btn_right && !i_btn_left) dx = STEP_S;
    else if (i_btn_left && !i_btn_right) dx = -STEP_S;
    if (i_btn_down && !i_btn_up) dy = STEP_S;
    else if (i_btn_up && !i_btn_down) dy = -STEP_S;
    nx     = clamp_coord(signed'(CALC_W'(o_ball_x)) + dx, MIN_S, MAX_X);
    ny     = clamp_coord(signed'(CALC_W'(o_ball_y)) + dy, MIN_S, MAX_Y);
    next_x = X_W'(nx);
    next_y = Y_W'(ny);
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q     <= ST_IDLE;
      o_ball_x    <= START_XV;
      o_ball_y    <= START_YV;
      centre_seen <= 1'b0;
      centre_safe <= 1'b0;
      start_prev  <= 1'b0;
    end else begin
      start_prev <= i_start;

      if (o_frame_tick) begin
        centre_seen <= 1'b0;
        centre_safe <= 1'b0;
      end else if (centre_hit) begin
        centre_seen <= 1'b1;
        centre_safe <= i_is_safe;
      end

      // Entering PLAY overrides the sampler so the first frame is a grace frame.
      case (state_q)
        ST_IDLE: begin
          o_ball_x <= START_XV;
          o_ball_y <= START_YV;
          if (start_rise) begin
            state_q     <= ST_PLAY;
            centre_seen <= 1'b0;
          end
        end
        ST_PLAY: begin
          if (o_frame_tick) begin
            if (centre_seen && !centre_safe) begin
              state_q <= ST_FAIL;
            end else begin
              o_ball_x <= next_x;
              o_ball_y <= next_y;
            end
          end
        end
        ST_FAIL: begin
          if (start_rise) begin
            state_q     <= ST_PLAY;
            o_ball_x    <= START_XV;
            o_ball_y    <= START_YV;
            centre_seen <= 1'b0;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign o_state = state_q;
endmodule
